// File: rtl/mem_access_unit.sv
// Multicycle byte-serial load/store initiator for a byte-wide data memory.
// Optional feature macro: MEM_ACCESS_MISALIGN_TRAP_EN (trap misaligned half/word requests).
module mem_access_unit #(
   parameter int MEM_AW = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata
);

   localparam logic [31:0] ADDR_MASK = (MEM_AW >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << MEM_AW) - 32'd1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t      state_r;
   logic [1:0]  cnt_r;
   logic [1:0]  size_r;
   logic        we_r;
   logic        uns_r;
   logic [31:0] wdata_r;
   logic [31:0] asm_r;
   logic [31:0] asm_s;
   logic [1:0]  cnt_next_s;
   logic        trap_s;

   // Index of the final byte of a transaction (size 11 behaves as word)
   function automatic logic [1:0] last_index(input logic [1:0] size);
      logic [1:0] idx;
      case (size)
         2'b00:   idx = 2'd0;
         2'b01:   idx = 2'd1;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

   function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] size,
                                               input logic zext);
      logic [31:0] res;
      case (size)
         2'b00:   res = zext ? {24'd0, raw[7:0]}   : {{24{raw[7]}}, raw[7:0]};
         2'b01:   res = zext ? {16'd0, raw[15:0]}  : {{16{raw[15]}}, raw[15:0]};
         default: res = raw;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] wrap_addr(input logic [31:0] a);
      return a & ADDR_MASK;
   endfunction

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
      logic mis;
      case (size)
         2'b00:   mis = 1'b0;
         2'b01:   mis = lsb[0];
         default: mis = (lsb != 2'b00);
      endcase
      return mis;
   endfunction
`endif

   // Assembly register with the byte arriving this cycle merged in, next byte index, trap decision
   always_comb begin
      asm_s = asm_r;
      asm_s[{cnt_r, 3'b000} +: 8] = mem_rdata;
      cnt_next_s = cnt_r + 2'd1;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      trap_s = misaligned(req_size, req_addr[1:0]);
`else
      trap_s = 1'b0;
`endif
   end

   // Transaction sequencer: IDLE -> ACCESS (one byte per cycle) -> DONE -> IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 2'd0;
         size_r     <= 2'd0;
         we_r       <= 1'b0;
         uns_r      <= 1'b0;
         wdata_r    <= 32'd0;
         asm_r      <= 32'd0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
         mem_addr   <= 32'd0;
         mem_we     <= 1'b0;
         mem_wdata  <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  we_r       <= req_we;
                  size_r     <= req_size;
                  uns_r      <= req_unsigned;
                  wdata_r    <= req_we ? req_wdata : 32'd0;
                  cnt_r      <= 2'd0;
                  req_ready  <= 1'b0;
                  resp_rdata <= 32'd0;
                  if (trap_s) begin
                     // Misaligned request is answered immediately without touching memory
                     state_r    <= ST_DONE;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else begin
                     state_r   <= ST_ACCESS;
                     resp_err  <= 1'b0;
                     mem_addr  <= wrap_addr(req_addr);
                     mem_we    <= req_we;
                     mem_wdata <= req_we ? req_wdata[7:0] : 8'd0;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            ST_ACCESS: begin
               asm_r <= asm_s;
               if (cnt_r == last_index(size_r)) begin
                  state_r    <= ST_DONE;
                  mem_we     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_rdata <= we_r ? 32'd0 : extend_load(asm_s, size_r, uns_r);
               end else begin
                  cnt_r     <= cnt_next_s;
                  mem_addr  <= wrap_addr(mem_addr + 32'd1);
                  mem_wdata <= wdata_r[{cnt_next_s, 3'b000} +: 8];
               end
            end
            ST_DONE: begin
               state_r    <= ST_IDLE;
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
            end
            default: begin
               state_r    <= ST_IDLE;
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               mem_we     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed cases plus randomized traffic vs. a byte-array model.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   logic [7:0]  mem     [0:65535];
   logic [7:0]  ref_mem [0:65535];
   logic        pre_en;
   logic [15:0] pre_addr;
   logic [7:0]  pre_data;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] addr_log[$];
   int          we_cycles;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.MEM_AW(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Byte memory: backdoor preload port, otherwise written by the DUT
   always @(posedge clk) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      else if (mem_we) mem[mem_addr[15:0]] <= mem_wdata;
   end
   assign mem_rdata = mem[mem_addr[15:0]];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic do_req(input logic we, input logic [1:0] size, input logic zext,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic use_const, input logic [31:0] const_val);
      int          n;
      int          cyc;
      logic        trap;
      logic [15:0] a16;
      logic [31:0] raw;
      logic [31:0] exp_d;
      exp_t        e;
      n = (size == 2'b00) ? 1 : ((size == 2'b01) ? 2 : 4);
      a16 = addr[15:0];
      trap = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      trap = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
`endif
      cyc = 0;
      while (!req_ready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("ready_before_req", {31'd0, req_ready}, 32'd1);
      addr_log.delete();
      we_cycles = 0;
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = zext;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      // Reference model: plain byte-array semantics
      if (trap) begin
         e.rdata = 32'd0; e.err = 1'b1;
      end else if (we) begin
         for (int i = 0; i < n; i++) ref_mem[a16 + 16'(i)] = wdata[8*i +: 8];
         e.rdata = 32'd0; e.err = 1'b0;
      end else begin
         raw = 32'd0;
         for (int i = 0; i < n; i++) raw[8*i +: 8] = ref_mem[a16 + 16'(i)];
         exp_d = raw;
         if (n < 4 && !zext && raw[8*n-1]) exp_d = raw | (32'hFFFF_FFFF << (8*n));
         e.rdata = use_const ? const_val : exp_d;
         e.err = 1'b0;
      end
      sb_q.push_back(e);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!resp_valid && cyc < 12);
      check("resp_latency", cyc, trap ? 32'd1 : 32'(n + 1));
      check("access_count", addr_log.size(), trap ? 32'd0 : 32'(n));
      for (int i = 0; i < addr_log.size() && i < n; i++)
         check("mem_addr_seq", addr_log[i], {16'd0, a16 + 16'(i)});
      check("we_cycles", we_cycles, (we && !trap) ? 32'(n) : 32'd0);
      @(negedge clk);
      check("ready_after_resp", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      int          mism;
      logic [31:0] w;
      logic [31:0] ra;
      logic [31:0] hi;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0; pre_en = 1'b1; pre_addr = 16'd0; pre_data = 8'd0;
      we_cycles = 0;

      // Monitor: logs memory accesses and pops the scoreboard on each response
      fork
         forever begin
            exp_t m;
            @(negedge clk);
            if (!rst) begin
               if (!req_ready && !resp_valid) addr_log.push_back(mem_addr);
               if (mem_we) we_cycles++;
               if (resp_valid) begin
                  if (sb_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL unexpected_resp actual=resp_valid expected=no response");
                  end else begin
                     m = sb_q.pop_front();
                     check("resp_rdata", resp_rdata, m.rdata);
                     check("resp_err", {31'd0, resp_err}, {31'd0, m.err});
                  end
               end
            end
         end
      join_none

      // Preload low and high regions, keeping the reference copy in step
      for (int i = 0; i < 2048; i++) begin
         @(negedge clk);
         pre_addr = (i < 1024) ? 16'(i) : 16'(16'hFC00 + (i - 1024));
         case (pre_addr)
            16'h0100: pre_data = 8'h11;
            16'h0101: pre_data = 8'h22;
            16'h0102: pre_data = 8'h33;
            16'h0103: pre_data = 8'h84;
            default:  pre_data = 8'($urandom);
         endcase
         ref_mem[pre_addr] = pre_data;
      end
      @(negedge clk);
      pre_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", {31'd0, resp_err}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);

      do_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0, 1'b1, 32'h8433_2211);
      do_req(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'd0, 1'b1, 32'hFFFF_FF84);
      do_req(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'd0, 1'b1, 32'h0000_0084);
      do_req(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'd0, 1'b1, 32'hFFFF_8433);
      do_req(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'd0, 1'b1, 32'h0000_8433);
      do_req(1'b1, 2'b01, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF, 1'b1, 32'd0);
      check("sh_mem200", {24'd0, mem[16'h0200]}, 32'h0000_00EF);
      check("sh_mem201", {24'd0, mem[16'h0201]}, 32'h0000_00BE);
      check("sh_mem202", {24'd0, mem[16'h0202]}, {24'd0, ref_mem[16'h0202]});
      do_req(1'b0, 2'b10, 1'b0, 32'h0000_FFFE, 32'd0, 1'b0, 32'd0);
      do_req(1'b0, 2'b11, 1'b1, 32'h1234_FFFE, 32'd0, 1'b0, 32'd0);
      do_req(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'd0, 1'b0, 32'd0);
      do_req(1'b1, 2'b10, 1'b0, 32'h0000_0031, 32'hA5C3_0F96, 1'b0, 32'd0);

      // Store aborted by reset after its first two bytes
      w = 32'hCAFE_F00D;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h0000_0300; req_wdata = w;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      ref_mem[16'h0300] = w[7:0];
      ref_mem[16'h0301] = w[15:8];
      @(negedge clk);
      check("abort_mem_we", {31'd0, mem_we}, 32'd0);
      check("abort_req_ready", {31'd0, req_ready}, 32'd1);
      check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
      repeat (4) @(negedge clk);
      for (int i = 0; i < 4; i++)
         check("abort_mem", {24'd0, mem[16'h0300 + 16'(i)]}, {24'd0, ref_mem[16'h0300 + 16'(i)]});

      for (int t = 0; t < 200; t++) begin
         hi = $urandom;
         ra = $urandom_range(0, 1) ? 32'($urandom_range(0, 1020)) : 32'($urandom_range(16'hFC00, 16'hFFFF));
         ra[31:16] = hi[15:0];
         do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ra, $urandom, 1'b0, 32'd0);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 32'd0);
      mism = 0;
      for (int i = 0; i < 65536; i++)
         if (mem[i] !== ref_mem[i]) mism++;
      check("final_mem_image", mism, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
